// File: rtl/data_memory_responder_pkg.sv
// mem_resp_pkg: shared types and helpers for the data-memory responder.
//   state_e      responder FSM states (IDLE, WAIT, RESP)
//   WORD_W       data word width in bits
//   idx_width()  word-index width for a given power-of-two depth
package mem_resp_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Number of bits needed to index 'depth' words (depth is a power of two).
  function automatic int unsigned idx_width(input int unsigned depth);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(depth)) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/data_memory_responder_if.sv
// data_memory_responder_if: CPU data-memory request/response bundle.
//   req_i   request valid (CPU -> responder)
//   we_i    1 = write, 0 = read
//   addr_i  byte address
//   wdata_i write data
//   ready_o responder can accept a request this cycle
//   ack_o   one-cycle response-valid pulse
//   rdata_o read data, valid with ack_o
//   err_o   misaligned/out-of-range flag, valid with ack_o
// Signal names keep the responder's port-direction suffixes.
interface data_memory_responder_if #(
  parameter int unsigned ADDR_W = 32
);
  import mem_resp_pkg::*;

  logic              req_i;
  logic              we_i;
  logic [ADDR_W-1:0] addr_i;
  logic [WORD_W-1:0] wdata_i;
  logic              ready_o;
  logic              ack_o;
  logic [WORD_W-1:0] rdata_o;
  logic              err_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i,
    input  ready_o, ack_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    output ready_o, ack_o, rdata_o, err_o
  );

endinterface

// File: rtl/data_memory_responder_mem_word_array.sv
// mem_word_array: DEPTH_WORDS x WORD_W storage, no reset.
//   clk_i    clock
//   we_i     synchronous write enable
//   waddr_i  write word index
//   wdata_i  write data
//   raddr_i  read word index
//   rdata_o  combinational read data
module mem_word_array
  import mem_resp_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic                                  clk_i,
  input  logic                                  we_i,
  input  logic [idx_width(DEPTH_WORDS)-1:0]     waddr_i,
  input  logic [WORD_W-1:0]                     wdata_i,
  input  logic [idx_width(DEPTH_WORDS)-1:0]     raddr_i,
  output logic [WORD_W-1:0]                     rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/data_memory_responder.sv
// data_memory_responder: responder end of the CPU data-memory port.
// Accepts one word read/write at a time, waits LATENCY cycles, then returns
// rdata/err with a one-cycle ack.
//   clk_i  clock, rising edge
//   rst_i  asynchronous active-low reset
//   bus    slave side of data_memory_responder_if
// Parameters: DEPTH_WORDS (power of two, >= 2), LATENCY (1..15), ADDR_W.
module data_memory_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  data_memory_responder_if.slave  bus
);

  localparam int unsigned IDX_W = idx_width(DEPTH_WORDS);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [IDX_W-1:0]  idx;
  logic              bad_addr;
  logic              mem_we;
  logic [WORD_W-1:0] mem_rdata;

  assign idx = addr_q[IDX_W+1:2];

  // Misaligned, or any bit above the word index set.
  assign bad_addr = (addr_q[1:0] != 2'b00) || ((addr_q >> (IDX_W + 2)) != '0);

  // Write commits on the WAIT->RESP edge; a reset in WAIT forces IDLE so no write.
  assign mem_we = (state_q == WAIT) && (cnt_q == '0) && we_q && !bad_addr;

  mem_word_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (mem_we),
    .waddr_i (idx),
    .wdata_i (wdata_q),
    .raddr_i (idx),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.req_i) begin
          we_d    = bus.we_i;
          addr_d  = bus.addr_i;
          wdata_d = bus.wdata_i;
          cnt_d   = 4'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rdata_d = (bad_addr || we_q) ? '0 : mem_rdata;
          err_d   = bad_addr;
          state_d = RESP;
        end
      end
      RESP: begin
        rdata_d = '0;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: begin
        rdata_d = '0;
        err_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // ready is gated by rst_i so it reads 0 while reset is held, even in IDLE.
  assign bus.ready_o = rst_i && (state_q == IDLE);
  assign bus.ack_o   = (state_q == RESP);
  assign bus.rdata_o = rdata_q;
  assign bus.err_o   = err_q;

endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Responder end of the CPU data-memory port: accepts word read/write requests from the pipeline's MEM stage over a ready/ack handshake.
- Services each request after a programmable number of wait states, then returns read data and an error flag with a one-cycle ack pulse.
- Replaces the zero-latency combinational data memory so the pipeline can be exercised against realistic memory latency.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words stored; must be a power of two, ≥ 2.
- LATENCY, 2, number of wait-state cycles between request acceptance and ack; legal range 1..15.
- ADDR_W, 32, request byte-address width.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- req_i  in  1  request valid from CPU.
- we_i  in  1  1 = write, 0 = read; sampled with req_i.
- addr_i  in  ADDR_W  byte address; sampled with req_i.
- wdata_i  in  32  write data; sampled with req_i.
- ready_o  out  1  responder can accept a request this cycle.
- ack_o  out  1  one-cycle pulse: response valid.
- rdata_o  out  32  read data; valid while ack_o = 1.
- err_o  out  1  request was misaligned or out of range; valid while ack_o = 1.

Behaviour:
- Reset (rst_i = 0, any time, asynchronous):
  - State goes to IDLE; wait counter and captured request clear.
  - Outputs during reset: ready_o = 0, ack_o = 0, rdata_o = 0, err_o = 0.
  - Memory array is not cleared.
  - After rst_i rises, ready_o = 1 from the first cycle.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - ready_o = 1, ack_o = 0.
  - When req_i = 1 at an edge (E0): capture we_i, addr_i, wdata_i; load cnt = LATENCY-1; go to WAIT.
  - When req_i = 0: stay in IDLE.
- WAIT:
  - ready_o = 0; req_i is ignored.
  - Each edge with cnt ≠ 0: cnt decrements.
  - Edge with cnt = 0: perform the access, register rdata_o and err_o, go to RESP.
- RESP:
  - ack_o = 1, ready_o = 0, for exactly one cycle.
  - Next edge: go to IDLE unconditionally; rdata_o and err_o return to 0.
- Timing:
  - Request accepted at E0 → ack_o high in the cycle after edge E0+LATENCY.
  - Earliest next acceptance is at edge E0+LATENCY+2.
  - A request held on req_i across RESP is accepted again in IDLE; the CPU deasserts req_i on seeing ack_o.
- Access rules:
  - Word index = addr[log2(DEPTH_WORDS)+1 : 2].
  - Error when addr[1:0] ≠ 0, or when any addr bit above the index is nonzero (out of range).
  - On error: no write occurs, rdata_o = 0, err_o = 1.
  - Valid read: rdata_o = mem[index].
  - Valid write: mem[index] ← wdata; rdata_o = 0, err_o = 0.
  - The write commits at the WAIT→RESP edge, so a read accepted after that ack returns the new data.
- Reset mid-transaction: a reset asserted in WAIT abandons the transaction with no memory write. A reset in RESP drops ack_o immediately.
- ack_o never asserts without a preceding accepted request. There is never more than one outstanding transaction.

Decomposition:
- Shared package mem_resp_pkg holds:
  - state enum (IDLE, WAIT, RESP);
  - WORD_W = 32;
  - function computing index width from DEPTH_WORDS.
- One sub-module: mem_word_array (DEPTH_WORDS × 32 storage).
  - Inputs: synchronous write enable, write index, write data.
  - Read port: combinational.
  - The responder FSM registers the read result itself.

Test Plan:
- Reset then idle: rst_i low 3 cycles → ready_o = 0, ack_o = 0. Release rst_i → ready_o = 1 next cycle; ack_o stays 0 for 20 idle cycles.
- Write then read (LATENCY = 2): write addr 0x10, data 0xDEADBEEF accepted at E0 → ack_o = 1 only in the cycle after E0+2, err_o = 0. Read addr 0x10 → rdata_o = 0xDEADBEEF with ack.
- Misaligned and out-of-range: write 0x12 (misaligned), then 0x400 with DEPTH_WORDS = 256 (out of range) → err_o = 1 on each ack. A following read of 0x10 still returns 0xDEADBEEF.
- Back-to-back with req_i held high: 4 reads of addrs 0x0/0x4/0x8/0xC → acks spaced LATENCY+2 = 4 cycles apart, each returning its own word. ready_o is never high in WAIT or RESP.
- Reset mid-operation: write 0x20 ← 0x12345678 accepted, rst_i pulsed low during WAIT → no ack. After release, a read of 0x20 returns the prior contents, not 0x12345678.
- LATENCY = 1 and LATENCY = 15 builds: ack_o appears in the cycle after E0+LATENCY for a single read; cover both counter boundaries.
